fcmp_sched: RTL and testbench

FCMP_SCHED -- requirements
Module: fcmp_sched

---
 rtl/fcmp_sched.sv | 184 ++++++++++++++++++
 tb/tb_fcmp_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fcmp_sched.sv
// Round-robin scheduler sharing one IEEE-754 single compare (feq/flt/fle) among NREQ requesters.
// Optional macro FCMP_SCHED_STICKY_NV_EN adds a sticky invalid (NaN) flag with nv_clr/nv_sticky.
module fcmp_sched #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [32*NREQ-1:0] req_x1,
  input  logic [32*NREQ-1:0] req_x2,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              rsp_y,
  output logic              rsp_nan
`ifdef FCMP_SCHED_STICKY_NV_EN
  ,
  input  logic              nv_clr,
  output logic              nv_sticky
`endif
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDXW-1:0] r_owner;
  logic [IDXW-1:0] r_last_grant;
  logic [IDXW-1:0] w_grant_idx;
  logic [IDXW-1:0] w_cand;
  logic            w_grant_any;
  logic            w_rsp_xfer;
  logic            w_can_grant;
  logic            w_accept;
  logic [1:0]      w_sel_op;
  logic [31:0]     w_sel_x1;
  logic [31:0]     w_sel_x2;
  logic [1:0]      w_cmp;
  logic            r_y;
  logic            r_nan;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Sign-magnitude ordering; both zeros are treated as equal regardless of sign.
  function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
    logic both_zero;
    logic lt;
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    if (both_zero)
      lt = 1'b0;
    else if (a[31] != b[31])
      lt = a[31];
    else if (!a[31])
      lt = a[30:0] < b[30:0];
    else
      lt = a[30:0] > b[30:0];
    return lt;
  endfunction

  function automatic logic f_eq(input logic [31:0] a, input logic [31:0] b);
    return (a == b) || ((a[30:0] == 31'd0) && (b[30:0] == 31'd0));
  endfunction

  // Returns {y, nan}.
  function automatic logic [1:0] f_cmp(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic nan;
    logic y;
    nan = is_nan(a) || is_nan(b);
    case (op)
      2'b00:   y = f_eq(a, b);
      2'b01:   y = f_lt(a, b);
      2'b10:   y = f_lt(a, b) || f_eq(a, b);
      default: y = 1'b0;
    endcase
    return {y & ~nan, nan};
  endfunction

  // Round-robin search: walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IDXW'((int'(r_last_grant) + k) % NREQ);
      if (req_valid[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign w_rsp_xfer  = (r_state == S_HOLD) && rsp_ready[r_owner];
  assign w_can_grant = (r_state == S_IDLE) || w_rsp_xfer;
  assign w_accept    = w_can_grant && w_grant_any && !rst;

  always_comb begin
    req_ready = '0;
    if (w_accept)
      req_ready[w_grant_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (r_state == S_HOLD)
      rsp_valid[r_owner] = 1'b1;
  end

  always_comb begin
    w_sel_op = 2'b00;
    w_sel_x1 = 32'd0;
    w_sel_x2 = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == IDXW'(i)) begin
        w_sel_op = req_op[2*i +: 2];
        w_sel_x1 = req_x1[32*i +: 32];
        w_sel_x2 = req_x2[32*i +: 32];
      end
    end
  end

  assign w_cmp = f_cmp(w_sel_op, w_sel_x1, w_sel_x2);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_rsp_xfer)
          w_state_nxt = w_accept ? S_HOLD : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result register stage: one held result, refilled in the same cycle it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_grant <= IDXW'(NREQ - 1);
      r_y          <= 1'b0;
      r_nan        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_y          <= w_cmp[1];
        r_nan        <= w_cmp[0];
      end
    end
  end

  assign rsp_y   = r_y;
  assign rsp_nan = r_nan;

`ifdef FCMP_SCHED_STICKY_NV_EN
  logic r_nv_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_nv_sticky <= 1'b0;
    else if (w_rsp_xfer && r_nan)
      r_nv_sticky <= 1'b1;
    else if (nv_clr)
      r_nv_sticky <= 1'b0;
  end

  assign nv_sticky = r_nv_sticky;
`endif

endmodule

// File: tb/tb_fcmp_sched.sv
// Directed self-checking bench for fcmp_sched (NREQ=2), optionally covering the sticky NaN flag.
module tb_fcmp_sched;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_x1;
  logic [63:0] req_x2;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic        rsp_y;
  logic        rsp_nan;
`ifdef FCMP_SCHED_STICKY_NV_EN
  logic        nv_clr;
  logic        nv_sticky;
`endif

  int checks;
  int failures;

  fcmp_sched #(.NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_nan   (rsp_nan)
`ifdef FCMP_SCHED_STICKY_NV_EN
    ,
    .nv_clr    (nv_clr),
    .nv_sticky (nv_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0]  t_op   [18];
  logic [31:0] t_x1   [18];
  logic [31:0] t_x2   [18];
  logic        t_y    [18];
  logic        t_nan  [18];

  initial begin
    int g;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 2'b11;
    req_op    = 4'b0000;
    req_x1    = 64'd0;
    req_x2    = 64'd0;
    rsp_ready = 2'b11;
`ifdef FCMP_SCHED_STICKY_NV_EN
    nv_clr    = 1'b0;
`endif

    t_op  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01,
              2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b10};
    t_x1  = '{32'h3F800000, 32'h00000000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
              32'hC0000000, 32'hC0000000, 32'hC0000000, 32'hBF800000, 32'h80000000,
              32'h80000000, 32'h7FC00000, 32'h3F800000, 32'h7F800000, 32'h3F800000,
              32'h7FC00000, 32'h3F800000, 32'h40000000};
    t_x2  = '{32'h3F800000, 32'h80000000, 32'h40000000, 32'h3F800000, 32'hBF800000,
              32'hC0000000, 32'hC0000000, 32'hBF800000, 32'hC0000000, 32'h00000000,
              32'h00000000, 32'h7FC00000, 32'h7F800001, 32'h7F800000, 32'h3F800000,
              32'h00000000, 32'h40000000, 32'h3F800000};
    t_y   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
              1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    t_nan = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    #3;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_y", 32'(rsp_y), 32'd0);
    check("rst_rsp_nan", 32'(rsp_nan), 32'd0);
    tick;
    check("rst_held_req_ready", 32'(req_ready), 32'd0);

    // Single request from requester 0: feq 1.0 == 1.0
    rst       = 1'b0;
    req_valid = 2'b01;
    req_op    = 4'b0000;
    req_x1    = {32'd0, 32'h3F800000};
    req_x2    = {32'd0, 32'h3F800000};
    #1;
    check("single_req_ready", 32'(req_ready), 32'b01);
    tick;
    req_valid = 2'b00;
    check("single_rsp_valid", 32'(rsp_valid), 32'b01);
    check("single_y", 32'(rsp_y), 32'd1);
    check("single_nan", 32'(rsp_nan), 32'd0);

    // Requester 1 NaN flt
    req_valid = 2'b10;
    req_op    = 4'b0100;
    req_x1    = {32'h7FC00000, 32'd0};
    req_x2    = {32'h3F800000, 32'd0};
    #1;
    check("nan_req_ready", 32'(req_ready), 32'b10);
    tick;
    req_valid = 2'b00;
    check("nan_rsp_valid", 32'(rsp_valid), 32'b10);
    check("nan_y", 32'(rsp_y), 32'd0);
    check("nan_nan", 32'(rsp_nan), 32'd1);
    tick;
    check("idle_after_xfer", 32'(rsp_valid), 32'd0);
`ifdef FCMP_SCHED_STICKY_NV_EN
    check("sticky_set", 32'(nv_sticky), 32'd1);
    tick;
    tick;
    check("sticky_hold", 32'(nv_sticky), 32'd1);
    nv_clr = 1'b1;
    tick;
    nv_clr = 1'b0;
    check("sticky_clr", 32'(nv_sticky), 32'd0);
`endif

    // Back-to-back compare vectors on requester 0
    for (int i = 0; i < 18; i++) begin
      req_valid = 2'b01;
      req_op    = {2'b00, t_op[i]};
      req_x1    = {32'd0, t_x1[i]};
      req_x2    = {32'd0, t_x2[i]};
      tick;
      check($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'b01);
      check($sformatf("vec%0d_y", i), 32'(rsp_y), 32'(t_y[i]));
      check($sformatf("vec%0d_nan", i), 32'(rsp_nan), 32'(t_nan[i]));
    end
    req_valid = 2'b00;
    tick;
    check("drain_idle", 32'(rsp_valid), 32'd0);

    // Fairness: requester 0 gives y=1 nan=0, requester 1 gives y=0 nan=1
    req_valid = 2'b11;
    req_op    = 4'b0100;
    req_x1    = {32'h7FC00000, 32'h3F800000};
    req_x2    = {32'h3F800000, 32'h3F800000};
    g = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d_req_ready", i), 32'(req_ready), 32'(1) << g);
      tick;
      check($sformatf("rr%0d_rsp_valid", i), 32'(rsp_valid), 32'(1) << g);
      check($sformatf("rr%0d_y", i), 32'(rsp_y), (g == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_nan", i), 32'(rsp_nan), (g == 0) ? 32'd0 : 32'd1);
      g = 1 - g;
    end

    // Backpressure while requester 0 owns the result
    rsp_ready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      if (i >= 3) rsp_ready = 2'b10;
      #1;
      check($sformatf("bp%0d_req_ready", i), 32'(req_ready), 32'd0);
      check($sformatf("bp%0d_rsp_valid", i), 32'(rsp_valid), 32'b01);
      check($sformatf("bp%0d_y", i), 32'(rsp_y), 32'd1);
      check($sformatf("bp%0d_nan", i), 32'(rsp_nan), 32'd0);
      tick;
    end
    rsp_ready = 2'b11;
    #1;
    check("bp_release_req_ready", 32'(req_ready), 32'b10);
    tick;
    check("bp_release_rsp_valid", 32'(rsp_valid), 32'b10);
    check("bp_release_nan", 32'(rsp_nan), 32'd1);

    // Asynchronous reset while holding
    rsp_ready = 2'b00;
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_req_ready", 32'(req_ready), 32'd0);
    check("async_rst_nan", 32'(rsp_nan), 32'd0);
    tick;
    rst       = 1'b0;
    rsp_ready = 2'b11;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'b01);
    tick;
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'b01);
    check("post_rst_y", 32'(rsp_y), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
